// File: rtl/ece241_q2_result_monitor.sv
// Result monitor for the ece241 q2 decoder: cross-checks SOP against POS,
// counts samples and hits, flags runs of hits and latches the first disagreement.
module ece241_q2_result_monitor #(
  parameter int CNT_W   = 16,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             sop,
  input  logic             pos,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] hit_count,
  output logic             run_pulse,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_index,
  output logic [1:0]       state
);

  // Handshake: in_valid alone qualifies sop/pos; there is no ready, every
  // valid cycle with resetn=1 and clear=0 is consumed, all others are ignored.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       RUN_LAST = 8'(RUN_LEN - 1);

  logic [7:0] run_cnt;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      sample_count <= '0;
      hit_count    <= '0;
      run_pulse    <= 1'b0;
      mismatch     <= 1'b0;
      err_index    <= '0;
      state        <= S_IDLE;
      run_cnt      <= '0;
    end else begin
      run_pulse <= 1'b0;
      if (in_valid) begin
        if (sample_count != CNT_MAX) sample_count <= sample_count + 1'b1;
        case (state)
          S_IDLE, S_TRACK: begin
            if (sop != pos) begin
              state     <= S_ERROR;
              mismatch  <= 1'b1;
              err_index <= sample_count;
              run_cnt   <= '0;
            end else begin
              state <= S_TRACK;
              if (sop) begin
                if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
                // Runs do not overlap: completing one restarts the count.
                if (run_cnt == RUN_LAST) begin
                  run_pulse <= 1'b1;
                  run_cnt   <= '0;
                end else begin
                  run_cnt <= run_cnt + 8'd1;
                end
              end else begin
                run_cnt <= '0;
              end
            end
          end
          S_ERROR: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ece241_q2_result_monitor.sv
// Directed bench for ece241_q2_result_monitor: one 16-bit instance and one
// 4-bit instance share all inputs; the narrow one exercises saturation.
module tb_ece241_q2_result_monitor;

  logic        clk;
  logic        resetn;
  logic        clear;
  logic        in_valid;
  logic        sop;
  logic        pos;

  logic [15:0] sample_count, hit_count, err_index;
  logic        run_pulse, mismatch;
  logic [1:0]  state;

  logic [3:0]  sample_count4, hit_count4, err_index4;
  logic        run_pulse4, mismatch4;
  logic [1:0]  state4;

  int n_checks;
  int n_fail;
  int pulse_cnt;
  int pulse_cnt4;

  ece241_q2_result_monitor #(.CNT_W(16), .RUN_LEN(3)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid),
    .sop(sop), .pos(pos), .sample_count(sample_count), .hit_count(hit_count),
    .run_pulse(run_pulse), .mismatch(mismatch), .err_index(err_index),
    .state(state)
  );

  ece241_q2_result_monitor #(.CNT_W(4), .RUN_LEN(3)) dut4 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid),
    .sop(sop), .pos(pos), .sample_count(sample_count4), .hit_count(hit_count4),
    .run_pulse(run_pulse4), .mismatch(mismatch4), .err_index(err_index4),
    .state(state4)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    pulse_cnt  = 0;
    pulse_cnt4 = 0;
  end

  always @(negedge clk) begin
    if (run_pulse)  pulse_cnt  <= pulse_cnt + 1;
    if (run_pulse4) pulse_cnt4 <= pulse_cnt4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send(input logic s, input logic p, output logic pulse);
    @(negedge clk);
    in_valid = 1'b1;
    sop      = s;
    pos      = p;
    @(posedge clk);
    #1;
    pulse = run_pulse;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic       pulse;
  logic [1:0] vec3 [6];
  logic [1:0] vec4 [6];
  int         p0, p1;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Test 1: reset held with a valid hit on the inputs
    resetn   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b1;
    sop      = 1'b1;
    pos      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sample_count", 32'(sample_count), 0);
    check("rst_hit_count",    32'(hit_count),    0);
    check("rst_run_pulse",    32'(run_pulse),    0);
    check("rst_mismatch",     32'(mismatch),     0);
    check("rst_err_index",    32'(err_index),    0);
    check("rst_state",        32'(state),        0);
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b1;

    // Test 2: six back-to-back hits (abcd = 7,15,2,7,15,2)
    p0 = pulse_cnt;
    for (int i = 1; i <= 6; i++) begin
      send(1'b1, 1'b1, pulse);
      check($sformatf("t2_pulse_%0d", i), 32'(pulse), 32'((i == 3 || i == 6) ? 1 : 0));
    end
    idle(1);
    check("t2_hit_count",    32'(hit_count),    6);
    check("t2_sample_count", 32'(sample_count), 6);
    check("t2_pulse_total",  32'(pulse_cnt - p0), 2);
    check("t2_run_pulse_low", 32'(run_pulse), 0);

    // Test 3: H,H,M,H,H,H with gaps
    do_clear();
    vec3 = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      send(vec3[i][1], vec3[i][0], pulse);
      check($sformatf("t3_pulse_%0d", i + 1), 32'(pulse), 32'((i == 5) ? 1 : 0));
      idle(2);
    end
    check("t3_hit_count",    32'(hit_count),    5);
    check("t3_sample_count", 32'(sample_count), 6);
    check("t3_state",        32'(state),        1);
    check("t3_pulse_total",  32'(pulse_cnt - p0), 1);

    // Test 4: MISS, HIT, SOP-only, then three hits
    do_clear();
    vec4 = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) send(vec4[i][1], vec4[i][0], pulse);
    idle(1);
    check("t4_mismatch",     32'(mismatch),     1);
    check("t4_err_index",    32'(err_index),    2);
    check("t4_state",        32'(state),        2);
    check("t4_hit_count",    32'(hit_count),    1);
    check("t4_sample_count", 32'(sample_count), 6);
    check("t4_pulse_total",  32'(pulse_cnt - p0), 0);

    // Test 5: clear together with a valid sample while in ERROR
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    sop      = 1'b1;
    pos      = 1'b1;
    @(posedge clk);
    #1;
    check("t5_sample_count", 32'(sample_count), 0);
    check("t5_hit_count",    32'(hit_count),    0);
    check("t5_run_pulse",    32'(run_pulse),    0);
    check("t5_mismatch",     32'(mismatch),     0);
    check("t5_err_index",    32'(err_index),    0);
    check("t5_state",        32'(state),        0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;

    // Test 6: 20 hits; the 4-bit instance saturates at 15
    do_clear();
    p0 = pulse_cnt;
    p1 = pulse_cnt4;
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1, pulse);
    idle(1);
    check("t6_sample_count4", 32'(sample_count4), 15);
    check("t6_hit_count4",    32'(hit_count4),    15);
    check("t6_pulse_total4",  32'(pulse_cnt4 - p1), 6);
    check("t6_state4",        32'(state4),        1);
    check("t6_mismatch4",     32'(mismatch4),     0);
    check("t6_err_index4",    32'(err_index4),    0);
    check("t6_sample_count",  32'(sample_count),  20);
    check("t6_hit_count",     32'(hit_count),     20);
    check("t6_pulse_total",   32'(pulse_cnt - p0), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
